// File: rtl/bist_pkg.sv
// Shared types and constants for the AND-tree BIST controller.
// Optional feature macro: BIST_DIRECTED_EN (adds the directed-pattern state).
package bist_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
`ifdef BIST_DIRECTED_EN
      DIRECTED = 3'd2,
`endif
      RANDOM   = 3'd3,
      DONE     = 3'd4
   } state_e;

   localparam logic [15:0] CRC_POLY       = 16'h1021;
   localparam logic [15:0] DEF_LFSR_SEED  = 16'hACE1;
   localparam logic [15:0] DEF_LFSR_TAPS  = 16'hB400;
   localparam int          FAIL_CNT_W     = 16;

   // One CRC-16 step: shift the signature left, fold in one response bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] sig, input logic bit_in);
      return {sig[14:0], 1'b0} ^ ((sig[15] ^ bit_in) ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois LFSR with synchronous load and step enable.
// next_value is the state one step ahead, so the owner can register it
// into its pattern output on the same edge the LFSR advances.
module bist_lfsr #(
   parameter int           W    = 16,
   parameter logic [W-1:0] SEED = W'(16'hACE1),
   parameter logic [W-1:0] TAPS = W'(16'hB400)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   output logic [W-1:0] next_value
);

   logic [W-1:0] value;

   assign next_value = (value >> 1) ^ (value[0] ? TAPS : '0);

   // Load takes priority over stepping; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         value <= '0;
      else if (load)
         value <= SEED;
      else if (en)
         value <= next_value;
   end

endmodule

// File: rtl/and_tree_bist.sv
// BIST controller for a 16-input AND-tree: drives patterns onto cut_in,
// compares cut_out with the AND-reduction of the applied pattern, counts
// mismatches, records the first failing pattern and folds every response
// into a CRC-16 signature.
// Optional feature macro: BIST_DIRECTED_EN (all-ones + walking-zero
// patterns applied before the pseudo-random phase).
module and_tree_bist
   import bist_pkg::*;
#(
   parameter int              N_IN      = 16,
   parameter int              NUM_PAT   = 1024,
   parameter logic [N_IN-1:0] LFSR_SEED = N_IN'(DEF_LFSR_SEED),
   parameter logic [N_IN-1:0] LFSR_TAPS = N_IN'(DEF_LFSR_TAPS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_IN-1:0]       cut_in,
   input  logic                  cut_out,
   output logic [FAIL_CNT_W-1:0] fail_cnt,
   output logic                  first_fail_valid,
   output logic [N_IN-1:0]       first_fail_pat,
   output logic [15:0]           signature
);

   localparam int              CNT_W    = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
   localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(NUM_PAT - 1);

`ifdef BIST_DIRECTED_EN
   localparam int              DIR_W    = $clog2(N_IN + 1);
   localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(N_IN);
   logic [DIR_W-1:0] dir_cnt;
`endif

   state_e           state;
   logic [CNT_W-1:0] pat_cnt;
   logic [N_IN-1:0]  lfsr_next;
   logic             checking;
   logic             mismatch;

   // Random-phase invariant: the LFSR state equals cut_in, so cut_in
   // advances to lfsr_next on the same edge the LFSR steps.
   bist_lfsr #(
      .W    (N_IN),
      .SEED (LFSR_SEED),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (state == LOAD),
      .en         (state == RANDOM),
      .next_value (lfsr_next)
   );

`ifdef BIST_DIRECTED_EN
   assign checking = (state == RANDOM) || (state == DIRECTED);
`else
   assign checking = (state == RANDOM);
`endif

   assign mismatch = checking && (cut_out != (&cut_in));
   assign busy     = checking || (state == LOAD);
   assign done     = (state == DONE);
   assign pass     = done && (fail_cnt == '0);

   // Run sequencing and the registered pattern bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pat_cnt <= '0;
         cut_in  <= '0;
`ifdef BIST_DIRECTED_EN
         dir_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start)
                  state <= LOAD;
            end
            LOAD: begin
               pat_cnt <= '0;
`ifdef BIST_DIRECTED_EN
               dir_cnt <= '0;
               cut_in  <= '1;
               state   <= DIRECTED;
`else
               cut_in  <= LFSR_SEED;
               state   <= RANDOM;
`endif
            end
`ifdef BIST_DIRECTED_EN
            DIRECTED: begin
               if (dir_cnt == DIR_LAST) begin
                  // LFSR was held at the seed throughout the directed phase.
                  cut_in <= LFSR_SEED;
                  state  <= RANDOM;
               end else begin
                  cut_in  <= ~(N_IN'(1) << dir_cnt);
                  dir_cnt <= dir_cnt + 1'b1;
               end
            end
`endif
            RANDOM: begin
               if (pat_cnt == LAST_PAT) begin
                  cut_in <= '0;
                  state  <= DONE;
               end else begin
                  cut_in  <= lfsr_next;
                  pat_cnt <= pat_cnt + 1'b1;
               end
            end
            default: begin
               cut_in <= '0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Result accumulation: cleared while leaving LOAD, updated once per pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_pat   <= '0;
         signature        <= '0;
      end else if (state == LOAD) begin
         fail_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_pat   <= '0;
         signature        <= '0;
      end else if (checking) begin
         signature <= crc16_step(signature, cut_out);
         if (mismatch) begin
            if (fail_cnt != '1)
               fail_cnt <= fail_cnt + 1'b1;
            if (!first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_pat   <= cut_in;
            end
         end
      end
   end

endmodule
